// File: rtl/result_checker.sv
// result_checker: arms on start, latches expected values and a channel mask,
// then watches live observed values until every enabled channel has matched
// for SETTLE_CYC consecutive cycles (pass) or TIMEOUT_CYC cycles pass (fail).
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   start, clear          arm a run / return from DONE to IDLE
//   ch_mask               channel enables, sampled at start
//   exp_data, obs_data    packed per-channel expected / observed values
//   busy, done            RUN / DONE indication
//   pass, fail, fail_ch   verdict and lowest mismatching channel on timeout
//   match_vec             registered per-channel match result
//   cycle_cnt             RUN cycles elapsed, frozen after the run
module result_checker #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned SETTLE_CYC  = 3,
   parameter int unsigned TIMEOUT_CYC = 1024,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned CNT_W      = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     start,
   input  logic                     clear,
   input  logic [NUM_CH-1:0]        ch_mask,
   input  logic [NUM_CH*DATA_W-1:0] exp_data,
   input  logic [NUM_CH*DATA_W-1:0] obs_data,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic                     fail,
   output logic [CH_W-1:0]          fail_ch,
   output logic [NUM_CH-1:0]        match_vec,
   output logic [CNT_W-1:0]         cycle_cnt
);

   localparam int unsigned STB_W = $clog2(SETTLE_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                    state_q, state_d;
   logic [NUM_CH*DATA_W-1:0]  exp_q, exp_d;
   logic [NUM_CH-1:0]         mask_q, mask_d;
   logic [STB_W-1:0]          stb_q, stb_d;
   logic [CNT_W-1:0]          cnt_d;
   logic                      busy_d, done_d, pass_d, fail_d;
   logic [CH_W-1:0]           fail_ch_d;
   logic [NUM_CH-1:0]         match_d;

   logic [NUM_CH-1:0]         mm_c;
   logic                      all_match_c;
   logic [CH_W-1:0]           first_mm_c;
   logic [STB_W-1:0]          stb_inc_c;
   logic                      settle_hit_c;
   logic                      timeout_hit_c;

   // Per-channel mismatch against the latched expectation; masked channels never mismatch
   always_comb begin
      mm_c = '0;
      for (int i = 0; i < int'(NUM_CH); i++)
         mm_c[i] = mask_q[i] & (obs_data[i*DATA_W +: DATA_W] != exp_q[i*DATA_W +: DATA_W]);
   end

   // Lowest mismatching channel: scan downward so the smallest index wins
   always_comb begin
      first_mm_c = '0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--)
         if (mm_c[i]) first_mm_c = CH_W'(i);
   end

   assign all_match_c   = ~|mm_c;
   assign stb_inc_c     = all_match_c ? stb_q + STB_W'(1) : '0;
   assign settle_hit_c  = (stb_inc_c == STB_W'(SETTLE_CYC));
   assign timeout_hit_c = (cycle_cnt == CNT_W'(TIMEOUT_CYC - 1));

   // State register
   always_ff @(posedge Clk) begin
      if (Reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (settle_hit_c || timeout_hit_c) state_d = S_DONE;
         S_DONE: begin
            if (start)      state_d = S_RUN;
            else if (clear) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values; pass takes precedence over timeout
   always_comb begin
      exp_d     = exp_q;
      mask_d    = mask_q;
      stb_d     = stb_q;
      cnt_d     = cycle_cnt;
      pass_d    = pass;
      fail_d    = fail;
      fail_ch_d = fail_ch;
      match_d   = match_vec;
      busy_d    = (state_d == S_RUN);
      done_d    = (state_d == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               exp_d  = exp_data;
               mask_d = ch_mask;
               stb_d  = '0;
               cnt_d  = '0;
            end
         end
         S_RUN: begin
            match_d = ~mm_c;
            stb_d   = stb_inc_c;
            cnt_d   = cycle_cnt + CNT_W'(1);
            if (settle_hit_c) begin
               pass_d = 1'b1;
               fail_d = 1'b0;
            end else if (timeout_hit_c) begin
               pass_d    = 1'b0;
               fail_d    = 1'b1;
               fail_ch_d = first_mm_c;
            end
         end
         S_DONE: begin
            if (start) begin
               exp_d     = exp_data;
               mask_d    = ch_mask;
               stb_d     = '0;
               cnt_d     = '0;
               pass_d    = 1'b0;
               fail_d    = 1'b0;
               fail_ch_d = '0;
            end else if (clear) begin
               pass_d    = 1'b0;
               fail_d    = 1'b0;
               fail_ch_d = '0;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs and latched run context
   always_ff @(posedge Clk) begin
      if (Reset) begin
         exp_q     <= '0;
         mask_q    <= '0;
         stb_q     <= '0;
         cycle_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         fail_ch   <= '0;
         match_vec <= '0;
      end else begin
         exp_q     <= exp_d;
         mask_q    <= mask_d;
         stb_q     <= stb_d;
         cycle_cnt <= cnt_d;
         busy      <= busy_d;
         done      <= done_d;
         pass      <= pass_d;
         fail      <= fail_d;
         fail_ch   <= fail_ch_d;
         match_vec <= match_d;
      end
   end

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker with two 32-bit channels, settle 3, timeout 16.
module tb_result_checker;

   localparam int unsigned NCH = 2;
   localparam int unsigned DW  = 32;

   logic          Clk = 1'b0;
   logic          Reset, start, clear;
   logic [1:0]    ch_mask;
   logic [63:0]   exp_data, obs_data;
   logic          busy, done, pass, fail;
   logic [0:0]    fail_ch;
   logic [1:0]    match_vec;
   logic [4:0]    cycle_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 Clk = ~Clk;

   result_checker #(
      .DATA_W(DW), .NUM_CH(NCH), .SETTLE_CYC(3), .TIMEOUT_CYC(16)
   ) dut (
      .Clk(Clk), .Reset(Reset), .start(start), .clear(clear),
      .ch_mask(ch_mask), .exp_data(exp_data), .obs_data(obs_data),
      .busy(busy), .done(done), .pass(pass), .fail(fail),
      .fail_ch(fail_ch), .match_vec(match_vec), .cycle_cnt(cycle_cnt)
   );

   typedef struct {
      bit        rst, st, clr;
      bit [1:0]  mask;
      bit [63:0] ex, ob;
      bit        e_busy, e_done, e_pass, e_fail;
      bit [0:0]  e_fch;
      bit [1:0]  e_mv;
      bit [4:0]  e_cnt;
   } vec_t;

   localparam bit [63:0] E5  = 64'h00000005_00000005;
   localparam bit [63:0] E79 = 64'h00000007_00000009;
   localparam bit [63:0] EAB = 64'h0000000A_0000000B;

   vec_t vecs[31];

   task automatic chk(input string nm, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   // Drive inputs away from the active edge, then sample just after it
   task automatic drive(input bit r, input bit s, input bit c, input bit [1:0] m,
                        input bit [63:0] e, input bit [63:0] o);
      @(negedge Clk);
      Reset = r; start = s; clear = c; ch_mask = m; exp_data = e; obs_data = o;
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_all(input string nm, input bit b, input bit d, input bit p,
                          input bit f, input bit [0:0] fc, input bit [1:0] mv,
                          input bit [4:0] cnt);
      chk({nm, ".busy"}, int'(busy), int'(b));
      chk({nm, ".done"}, int'(done), int'(d));
      chk({nm, ".pass"}, int'(pass), int'(p));
      chk({nm, ".fail"}, int'(fail), int'(f));
      chk({nm, ".fail_ch"}, int'(fail_ch), int'(fc));
      chk({nm, ".match_vec"}, int'(match_vec), int'(mv));
      chk({nm, ".cycle_cnt"}, int'(cycle_cnt), int'(cnt));
   endtask

   // Full-length run: ch1 (or both) mismatch until RUN cycle mf, then all match
   task automatic run_timeout(input string nm, input int mf, input bit [63:0] bad,
                              input bit e_pass, input bit [0:0] e_fch, input bit [1:0] e_mv);
      drive(1, 0, 0, 2'b00, 64'h0, 64'h0);
      drive(0, 1, 0, 2'b11, EAB, bad);
      chk({nm, ".armed"}, int'(busy), 1);
      for (int k = 1; k <= 16; k++) begin
         drive(0, 0, 0, 2'b00, 64'h0, (k >= mf) ? EAB : bad);
         if (k == 15) begin
            chk({nm, ".c15_done"}, int'(done), 0);
            chk({nm, ".c15_cnt"}, int'(cycle_cnt), 15);
         end
      end
      chk_all({nm, ".end"}, 0, 1, e_pass, !e_pass, e_fch, e_mv, 5'd16);
      drive(0, 0, 0, 2'b00, 64'h0, 64'h0);
      chk_all({nm, ".hold"}, 0, 1, e_pass, !e_pass, e_fch, e_mv, 5'd16);
   endtask

   initial begin
      Reset = 1'b1; start = 1'b0; clear = 1'b0;
      ch_mask = '0; exp_data = '0; obs_data = '0;

      //          rst st clr mask  exp  obs                     bsy dn ps fl fc mv  cnt
      vecs[0]  = '{1, 0, 0, 2'd0, 64'h0, 64'h0,                  0, 0, 0, 0, 0, 2'd0, 5'd0};
      vecs[1]  = '{0, 1, 0, 2'd3, E5,    E5,                     1, 0, 0, 0, 0, 2'd0, 5'd0};
      vecs[2]  = '{0, 0, 0, 2'd0, 64'h0, E5,                     1, 0, 0, 0, 0, 2'd3, 5'd1};
      vecs[3]  = '{0, 0, 0, 2'd0, 64'h0, E5,                     1, 0, 0, 0, 0, 2'd3, 5'd2};
      vecs[4]  = '{0, 0, 0, 2'd0, 64'h0, E5,                     0, 1, 1, 0, 0, 2'd3, 5'd3};
      vecs[5]  = '{0, 0, 0, 2'd0, 64'h0, 64'h0,                  0, 1, 1, 0, 0, 2'd3, 5'd3};
      vecs[6]  = '{0, 0, 1, 2'd0, 64'h0, 64'h0,                  0, 0, 0, 0, 0, 2'd3, 5'd3};
      vecs[7]  = '{0, 0, 1, 2'd0, 64'h0, 64'h0,                  0, 0, 0, 0, 0, 2'd3, 5'd3};
      vecs[8]  = '{0, 1, 0, 2'd3, E79,   E79,                    1, 0, 0, 0, 0, 2'd3, 5'd0};
      vecs[9]  = '{0, 1, 0, 2'd3, 64'h0, E79,                    1, 0, 0, 0, 0, 2'd3, 5'd1};
      vecs[10] = '{0, 0, 0, 2'd0, 64'h0, E79,                    1, 0, 0, 0, 0, 2'd3, 5'd2};
      vecs[11] = '{0, 0, 0, 2'd0, 64'h0, 64'h00000007_00000000,  1, 0, 0, 0, 0, 2'd2, 5'd3};
      vecs[12] = '{0, 0, 0, 2'd0, 64'h0, E79,                    1, 0, 0, 0, 0, 2'd3, 5'd4};
      vecs[13] = '{0, 0, 0, 2'd0, 64'h0, E79,                    1, 0, 0, 0, 0, 2'd3, 5'd5};
      vecs[14] = '{0, 0, 0, 2'd0, 64'h0, E79,                    0, 1, 1, 0, 0, 2'd3, 5'd6};
      vecs[15] = '{0, 1, 0, 2'd0, 64'h0, 64'h00000001_00000002,  1, 0, 0, 0, 0, 2'd3, 5'd0};
      vecs[16] = '{0, 0, 0, 2'd3, E5,    64'h00000001_00000002,  1, 0, 0, 0, 0, 2'd3, 5'd1};
      vecs[17] = '{0, 0, 0, 2'd0, 64'h0, 64'h00000001_00000002,  1, 0, 0, 0, 0, 2'd3, 5'd2};
      vecs[18] = '{0, 0, 0, 2'd0, 64'h0, 64'h00000001_00000002,  0, 1, 1, 0, 0, 2'd3, 5'd3};
      vecs[19] = '{0, 1, 0, 2'd2, 64'h00000003_00000000, 64'h00000003_00000008, 1, 0, 0, 0, 0, 2'd3, 5'd0};
      vecs[20] = '{0, 0, 0, 2'd0, 64'h0, 64'h00000003_00000008,  1, 0, 0, 0, 0, 2'd3, 5'd1};
      vecs[21] = '{0, 0, 0, 2'd0, 64'h0, 64'h00000004_00000008,  1, 0, 0, 0, 0, 2'd1, 5'd2};
      vecs[22] = '{0, 0, 0, 2'd0, 64'h0, 64'h00000003_00000008,  1, 0, 0, 0, 0, 2'd3, 5'd3};
      vecs[23] = '{0, 0, 0, 2'd0, 64'h0, 64'h00000003_00000008,  1, 0, 0, 0, 0, 2'd3, 5'd4};
      vecs[24] = '{1, 1, 1, 2'd3, E5,    64'h00000003_00000008,  0, 0, 0, 0, 0, 2'd0, 5'd0};
      vecs[25] = '{0, 1, 0, 2'd3, E5,    E5,                     1, 0, 0, 0, 0, 2'd0, 5'd0};
      vecs[26] = '{0, 0, 0, 2'd0, 64'h0, E5,                     1, 0, 0, 0, 0, 2'd3, 5'd1};
      vecs[27] = '{0, 0, 0, 2'd0, 64'h0, E5,                     1, 0, 0, 0, 0, 2'd3, 5'd2};
      vecs[28] = '{0, 0, 0, 2'd0, 64'h0, E5,                     0, 1, 1, 0, 0, 2'd3, 5'd3};
      vecs[29] = '{0, 1, 1, 2'd3, E5,    E5,                     1, 0, 0, 0, 0, 2'd3, 5'd0};
      vecs[30] = '{1, 0, 0, 2'd0, 64'h0, 64'h0,                  0, 0, 0, 0, 0, 2'd0, 5'd0};

      for (int i = 0; i < 31; i++) begin
         drive(vecs[i].rst, vecs[i].st, vecs[i].clr, vecs[i].mask, vecs[i].ex, vecs[i].ob);
         chk_all($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_done, vecs[i].e_pass,
                 vecs[i].e_fail, vecs[i].e_fch, vecs[i].e_mv, vecs[i].e_cnt);
      end

      // ch1 never matches: timeout, ch1 reported
      run_timeout("to_ch1", 99, 64'h00000000_0000000B, 1'b0, 1'b1, 2'b01);
      // both channels wrong: lowest index reported
      run_timeout("to_both", 99, 64'h0, 1'b0, 1'b0, 2'b00);
      // matching only over the last two cycles: timeout with no live mismatch
      run_timeout("to_late", 15, 64'h00000000_0000000B, 1'b0, 1'b0, 2'b11);
      // settle completes on the timeout cycle: pass wins
      run_timeout("pass_edge", 14, 64'h00000000_0000000B, 1'b1, 1'b0, 2'b11);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
